// File: rtl/fb_pattern_fill_if.sv
// Pixel write bus between the pattern generator and the frame-buffer sink.
// The producer holds wr/wr_addr/wr_data; the sink answers with wr_ready.
interface fb_pattern_fill_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 32
) ();
  logic              wr;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/fb_pattern_fill.sv
// Frame-buffer pattern filler: walks every pixel of an H x V frame once,
// emitting one write per pixel with a solid, bar, checker or gradient value.
module fb_pattern_fill #(
  parameter int                H          = 640,
  parameter int                V          = 400,
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                CHECK_LOG2 = 3,
  parameter logic [DATA_W-1:0] BAR0       = 8'hE0,
  parameter logic [DATA_W-1:0] BAR1       = 8'h1C,
  parameter logic [DATA_W-1:0] BAR2       = 8'h03
) (
  input  logic                 pclk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    color,
  fb_pattern_fill_if.master    wr_bus,
  output logic                 busy,
  output logic                 done
);

  localparam int XW = (H > 1) ? $clog2(H) : 1;
  localparam int YW = (V > 1) ? $clog2(V) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V - 1);
  localparam logic [XW-1:0] BAR1_X = XW'(H / 3);
  localparam logic [XW-1:0] BAR2_X = XW'((2 * H) / 3);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_reg, state_next;
  logic [XW-1:0]     x_reg, x_next;
  logic [YW-1:0]     y_reg, y_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        mode_reg, mode_next;
  logic [DATA_W-1:0] color_reg, color_next;
  logic              done_reg, done_next;

  logic [DATA_W-1:0] grad;
  logic [DATA_W-1:0] pix;
  logic              chk_x, chk_y;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      addr_reg  <= BASE_ADDR;
      mode_reg  <= '0;
      color_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      addr_reg  <= addr_next;
      mode_reg  <= mode_next;
      color_reg <= color_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    addr_next  = addr_reg;
    mode_next  = mode_reg;
    color_next = color_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FILL;
          x_next     = '0;
          y_next     = '0;
          addr_next  = BASE_ADDR;
          mode_next  = mode;
          color_next = color;
        end
      end
      FILL: begin
        if (wr_bus.wr_ready) begin
          addr_next = addr_reg + 1'b1;
          if (x_reg == X_LAST) begin
            x_next = '0;
            if (y_reg == Y_LAST) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              y_next = y_reg + 1'b1;
            end
          end else begin
            x_next = x_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gradient takes the low DATA_W bits of x, zero-padded when x is narrower.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_grad
    if (gi < XW) begin : g_bit
      assign grad[gi] = x_reg[gi];
    end else begin : g_zero
      assign grad[gi] = 1'b0;
    end
  end

  // Bit 0 of (coord >> CHECK_LOG2) is simply coord[CHECK_LOG2].
  if (CHECK_LOG2 < XW) begin : g_chk_x
    assign chk_x = x_reg[CHECK_LOG2];
  end else begin : g_chk_x0
    assign chk_x = 1'b0;
  end
  if (CHECK_LOG2 < YW) begin : g_chk_y
    assign chk_y = y_reg[CHECK_LOG2];
  end else begin : g_chk_y0
    assign chk_y = 1'b0;
  end

  // Pixel value is a pure function of the current (x,y), so data and address
  // always describe the same pixel and both hold naturally during a stall.
  always_comb begin
    pix = color_reg;
    case (mode_reg)
      2'd0: pix = color_reg;
      2'd1: begin
        if (x_reg < BAR1_X)      pix = BAR0;
        else if (x_reg < BAR2_X) pix = BAR1;
        else                     pix = BAR2;
      end
      2'd2:    pix = (chk_x ^ chk_y) ? '1 : '0;
      default: pix = grad;
    endcase
  end

  assign wr_bus.wr      = (state_reg == FILL);
  assign wr_bus.wr_addr = addr_reg;
  assign wr_bus.wr_data = (state_reg == FILL) ? pix : '0;
  assign busy           = (state_reg == FILL);
  assign done           = done_reg;

endmodule

// File: tb/tb_fb_pattern_fill.sv
// Directed bench for fb_pattern_fill on an 8x4 frame with 2-pixel checker squares.
module tb_fb_pattern_fill;

  localparam int H = 8;
  localparam int V = 4;
  localparam int NPIX = H * V;

  logic       pclk;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [7:0] color;
  logic       busy;
  logic       done;

  int compared;
  int mismatched;

  fb_pattern_fill_if #(.DATA_W(8), .ADDR_W(32)) bus ();

  fb_pattern_fill #(
    .H(H), .V(V), .DATA_W(8), .ADDR_W(32), .BASE_ADDR(32'd0), .CHECK_LOG2(1),
    .BAR0(8'hE0), .BAR1(8'h1C), .BAR2(8'h03)
  ) dut (
    .pclk  (pclk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .color (color),
    .wr_bus(bus.master),
    .busy  (busy),
    .done  (done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One fill per record: lines 0-1 expect row_a, lines 2-3 expect row_b.
  typedef struct {
    logic [1:0] mode;
    logic [7:0] color;
    bit         stall;
    bit         poke_start;
    logic [7:0] row_a[8];
    logic [7:0] row_b[8];
  } fill_vec_t;

  fill_vec_t vec[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_fill(input int idx, input bit pre_started, input bit chain_out);
    fill_vec_t   t;
    int          count;
    int          cyc;
    bit          prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_data;
    logic [7:0]  exp_data;
    bit          rdy;
    t = vec[idx];
    if (!pre_started) begin
      @(negedge pclk);
      mode  = t.mode;
      color = t.color;
      start = 1'b1;
      @(negedge pclk);
    end
    start = 1'b0;
    // Inputs wander during the fill; the latched values must win.
    mode  = ~t.mode;
    color = ~t.color;
    count = 0;
    prev_stall = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    cyc = 0;
    while (count < NPIX && cyc < 400) begin
      check("wr_high", {31'd0, bus.wr}, 32'd1);
      check("busy_high", {31'd0, busy}, 32'd1);
      check("done_low", {31'd0, done}, 32'd0);
      check("addr", bus.wr_addr, count);
      exp_data = ((count / H) < 2) ? t.row_a[count % H] : t.row_b[count % H];
      check("data", {24'd0, bus.wr_data}, {24'd0, exp_data});
      if (prev_stall) begin
        check("hold_addr", bus.wr_addr, prev_addr);
        check("hold_data", {24'd0, bus.wr_data}, {24'd0, prev_data});
      end
      start = (t.poke_start && count == 5) ? 1'b1 : 1'b0;
      rdy = t.stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.wr_ready = rdy;
      prev_stall = !rdy;
      prev_addr = bus.wr_addr;
      prev_data = bus.wr_data;
      if (rdy) count++;
      cyc++;
      @(negedge pclk);
    end
    start = 1'b0;
    if (count < NPIX) check("fill_timeout", count, NPIX);
    check("end_wr_low", {31'd0, bus.wr}, 32'd0);
    check("end_busy_low", {31'd0, busy}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd1);
    bus.wr_ready = 1'b1;
    if (chain_out) begin
      mode  = vec[idx + 1].mode;
      color = vec[idx + 1].color;
      start = 1'b1;
    end
    @(negedge pclk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    if (!chain_out) begin
      check("idle_wr_low", {31'd0, bus.wr}, 32'd0);
      @(negedge pclk);
      check("no_extra_fill", {31'd0, busy}, 32'd0);
    end else begin
      check("chain_busy", {31'd0, busy}, 32'd1);
    end
    $display("fill %0d: mode=%0d transfers=%0d cycles=%0d", idx, t.mode, count, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    compared = 0;
    mismatched = 0;
    vec[0] = '{mode: 2'd0, color: 8'h5A, stall: 1'b0, poke_start: 1'b0,
               row_a: '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A},
               row_b: '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A}};
    vec[1] = '{mode: 2'd1, color: 8'h00, stall: 1'b0, poke_start: 1'b0,
               row_a: '{8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h1C, 8'h03, 8'h03, 8'h03},
               row_b: '{8'hE0, 8'hE0, 8'h1C, 8'h1C, 8'h1C, 8'h03, 8'h03, 8'h03}};
    vec[2] = '{mode: 2'd2, color: 8'h77, stall: 1'b0, poke_start: 1'b1,
               row_a: '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF},
               row_b: '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00}};
    vec[3] = '{mode: 2'd3, color: 8'h00, stall: 1'b1, poke_start: 1'b0,
               row_a: '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07},
               row_b: '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07}};
    vec[4] = '{mode: 2'd0, color: 8'hA5, stall: 1'b1, poke_start: 1'b1,
               row_a: '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5},
               row_b: '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5}};

    reset = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    color = 8'h00;
    bus.wr_ready = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_wr", {31'd0, bus.wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", bus.wr_addr, 32'd0);
    check("rst_data", {24'd0, bus.wr_data}, 32'd0);
    reset = 1'b0;
    @(negedge pclk);
    check("idle_no_start", {31'd0, busy}, 32'd0);

    run_fill(0, 1'b0, 1'b0);
    run_fill(1, 1'b0, 1'b1);
    run_fill(2, 1'b1, 1'b0);
    run_fill(3, 1'b0, 1'b0);

    // Abort a fill after 10 transfers; reset must also beat a concurrent start.
    @(negedge pclk);
    mode = 2'd0;
    color = 8'h11;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    bus.wr_ready = 1'b1;
    repeat (10) @(negedge pclk);
    check("pre_abort_addr", bus.wr_addr, 32'd10);
    reset = 1'b1;
    start = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    start = 1'b0;
    check("abort_wr", {31'd0, bus.wr}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_addr", bus.wr_addr, 32'd0);
    check("abort_data", {24'd0, bus.wr_data}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      check("abort_quiet_wr", {31'd0, bus.wr}, 32'd0);
      check("abort_quiet_done", {31'd0, done}, 32'd0);
    end
    $display("abort: reset after 10 transfers");

    run_fill(4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fb_pattern_fill.md
FB_PATTERN_FILL -- requirements
Module: fb_pattern_fill

Interface
REQ-001 Parameter H, default 640: frame width in pixels.
REQ-002 Parameter V, default 400: frame height in lines.
REQ-003 Parameter DATA_W, default 8: pixel width; default format RGB332.
REQ-004 Parameter ADDR_W, default 32: write-address width.
REQ-005 Parameter BASE_ADDR, default 0: address of pixel (0,0).
REQ-006 Parameter CHECK_LOG2, default 3: checkerboard square size is 2^CHECK_LOG2 pixels.
REQ-007 Parameters BAR0, BAR1, BAR2, defaults 8'hE0, 8'h1C, 8'h03: colour-bar colours (red, green, blue).
REQ-008 pclk  in  1  sole clock; all logic on the rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 start  in  1  fill request; sampled only in IDLE.
REQ-011 mode  in  2  pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 gradient.
REQ-012 color  in  DATA_W  solid-fill colour for mode 0.
REQ-013 wr_ready  in  1  sink accepts the write presented this cycle.
REQ-014 wr  out  1  write request; a transfer occurs when wr and wr_ready are both 1.
REQ-015 wr_addr  out  ADDR_W  pixel address.
REQ-016 wr_data  out  DATA_W  pixel value.
REQ-017 busy  out  1  high while in FILL.
REQ-018 done  out  1  one-cycle pulse after the last transfer.

Function
REQ-019 States: IDLE, FILL. Hold IDLE while start=0.
REQ-020 Start: start=1 in IDLE latches mode and color, sets x=0, y=0, wr_addr=BASE_ADDR, and enters FILL on the next edge; wr=1 and busy=1 from that cycle.
REQ-021 Latched mode and color are not affected by changes to mode or color during FILL.
REQ-022 start is ignored in FILL; no queuing.
REQ-023 In FILL, wr=1 continuously; wr_addr and wr_data stay stable while wr_ready=0.
REQ-024 On each transfer, x increments; when x=H-1, x wraps to 0 and y increments.
REQ-025 wr_addr = BASE_ADDR + y*H + x, incremented by 1 per transfer, modulo 2^ADDR_W.
REQ-026 Mode 0: wr_data = latched color.
REQ-027 Mode 1: wr_data = BAR0 for x < H/3; BAR1 for H/3 <= x < 2H/3; BAR2 otherwise (integer division).
REQ-028 Mode 2: wr_data = all-ones if bit 0 of ((x>>CHECK_LOG2) XOR (y>>CHECK_LOG2)) is 1, else 0.
REQ-029 Mode 3: wr_data = x[DATA_W-1:0], wrapping every 2^DATA_W pixels.
REQ-030 wr_data corresponds to the current (x,y) in the same cycle that wr_addr is presented; an internal pipeline shall not be visible at the ports.
REQ-031 Last pixel: the transfer at x=H-1, y=V-1 returns the block to IDLE; on the next cycle wr=0, busy=0, and done=1 for exactly one cycle.
REQ-032 start=1 in the cycle where done=1 begins a new fill (IDLE-entry rules apply).
REQ-033 Total transfers per fill = H*V exactly; no address is repeated or skipped.
REQ-034 wr_ready=1 when wr=0 has no effect.

Reset
REQ-035 reset=1 forces, on the next edge: state IDLE, wr=0, busy=0, done=0, wr_addr=BASE_ADDR, wr_data=0, x=0, y=0.
REQ-036 Reset during FILL aborts the fill: no done pulse, no further writes; reset takes priority over start.

Verification (bench H=8, V=4, CHECK_LOG2=1)
REQ-037 Apply mode=0, color=8'h5A, start pulse, wr_ready=1 -> 32 transfers at addresses 0..31, all with data 5A; done pulses one cycle after the transfer at address 31.
REQ-038 Apply mode=1 -> per line, x=0,1 give E0; x=2..4 give 1C; x=5..7 give 03.
REQ-039 Apply mode=2 -> line 0 data is 00,00,FF,FF,00,00,FF,FF; line 2 data is FF,FF,00,00,FF,FF,00,00.
REQ-040 Apply mode=3 and toggle wr_ready randomly -> data equals x, addresses remain contiguous, and wr_addr/wr_data are held across every stall cycle.
REQ-041 Assert reset after 10 transfers -> wr=0 on the next cycle, no done; a subsequent start restarts at BASE_ADDR.
REQ-042 Pulse start again while busy -> the pulse is ignored and the transfer count is exactly 32.
